// File: rtl/id_branch_unit.sv
// IF/ID pipeline register with decode-stage branch/jump resolution and load-use hazard detection.
// Latency: register outputs 1 cycle after fetch, all control outputs combinational; stall freezes the IF/ID register and holds fetch.
module id_branch_unit (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] if_pc4,
    input  logic [31:0] if_inst,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [1:0]  pcsource,
    output logic [31:0] bpc,
    output logic [31:0] jpc,
    output logic        stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BPC = 2'b01;
    localparam logic [1:0] PCSRC_JPC = 2'b10;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } inst_t;

    inst_t      dec;
    logic [5:0] func;
    logic       is_beq;
    logic       is_bne;
    logic       is_jump;
    logic       is_jr;
    logic       uses_rs;
    logic       uses_rt;
    logic       ops_equal;
    logic       branch_taken;

    // Reset clears the captured instruction to a nop, which keeps stall and pcsource quiet.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            id_pc4  <= 32'h0;
            id_inst <= 32'h0;
        end else if (!stall) begin
            id_pc4  <= if_pc4;
            id_inst <= if_inst;
        end
    end

    assign dec  = inst_t'(id_inst);
    assign func = dec.imm[5:0];
    assign rs   = dec.rs;
    assign rt   = dec.rt;

    assign is_beq  = (dec.op == OP_BEQ);
    assign is_bne  = (dec.op == OP_BNE);
    assign is_jr   = (dec.op == OP_RTYPE) && (func == FUNC_JR);
    assign is_jump = (dec.op == OP_J) || (dec.op == OP_JAL) || is_jr;

    assign uses_rs = (dec.op != OP_J) && (dec.op != OP_JAL);
    assign uses_rt = (dec.op == OP_RTYPE) || is_beq || is_bne || (dec.op == OP_SW);

    // $0 is never a real producer, so a load targeting it cannot create a hazard.
    assign stall = ex_m2reg && (ex_rn != 5'd0) &&
                   (((ex_rn == dec.rs) && uses_rs) || ((ex_rn == dec.rt) && uses_rt));

    assign ops_equal    = (rs_data == rt_data);
    assign branch_taken = (is_beq && ops_equal) || (is_bne && !ops_equal);

    // Redirect is suppressed while stalled: the compared operands are not yet valid.
    always_comb begin
        pcsource = PCSRC_PC4;
        if (!stall) begin
            if (branch_taken)
                pcsource = PCSRC_BPC;
            else if (is_jump)
                pcsource = PCSRC_JPC;
        end
    end

    assign bpc = id_pc4 + {{14{dec.imm[15]}}, dec.imm, 2'b00};
    assign jpc = is_jr ? rs_data : {id_pc4[31:28], id_inst[25:0], 2'b00};

endmodule

// File: tb/tb_id_branch_unit.sv
// Self-checking bench for id_branch_unit: directed vector table, hand-written multi-cycle sequences, randomized model comparison.
module tb_id_branch_unit;

    logic        clk;
    logic        clrn;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        ex_m2reg;
    logic [4:0]  ex_rn;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic        stall;

    int checks = 0;
    int errors = 0;

    id_branch_unit dut (
        .clk(clk), .clrn(clrn), .if_pc4(if_pc4), .if_inst(if_inst),
        .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .rs_data(rs_data), .rt_data(rt_data),
        .id_pc4(id_pc4), .id_inst(id_inst), .rs(rs), .rt(rt),
        .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        m2reg;
        logic [4:0]  exrn;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [1:0]  exp_pcsrc;
        logic        exp_stall;
        logic [31:0] exp_bpc;
        logic [31:0] exp_jpc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: classify the instruction by mnemonic, then apply the hazard and redirect rules.
    function automatic void model(input logic [31:0] pc4, input logic [31:0] inst, input logic m2,
                                  input logic [4:0] exrn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] ps, output logic [31:0] bp,
                                  output logic [31:0] jp, output logic st);
        int op;
        int fn;
        int rsf;
        int rtf;
        bit jr;
        bit jmp;
        bit rs_used;
        bit rt_used;
        op  = int'(inst[31:26]);
        fn  = int'(inst[5:0]);
        rsf = int'(inst[25:21]);
        rtf = int'(inst[20:16]);
        jr  = (op == 0) && (fn == 8);
        jmp = (op == 2) || (op == 3) || jr;
        rs_used = !((op == 2) || (op == 3));
        rt_used = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        st = m2 && (exrn != 0) && ((int'(exrn) == rsf && rs_used) || (int'(exrn) == rtf && rt_used));
        bp = pc4 + 32'($signed(inst[15:0]) * 4);
        jp = jr ? a : ((pc4 & 32'hF000_0000) | (32'(inst[25:0]) * 4));
        if (st)                        ps = 2'd0;
        else if (op == 4 && a == b)    ps = 2'd1;
        else if (op == 5 && a != b)    ps = 2'd1;
        else if (jmp)                  ps = 2'd2;
        else                           ps = 2'd0;
    endfunction

    task automatic load(input logic [31:0] pc4, input logic [31:0] inst);
        @(negedge clk);
        if_pc4   = pc4;
        if_inst  = inst;
        ex_m2reg = 1'b0;
        ex_rn    = 5'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] pc4, input logic [31:0] inst, input logic m2,
                           input logic [4:0] exrn, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] ps, input logic st, input logic [31:0] bp,
                           input logic [31:0] jp);
        vec_t v;
        v.pc4 = pc4; v.inst = inst; v.m2reg = m2; v.exrn = exrn; v.rsd = a; v.rtd = b;
        v.exp_pcsrc = ps; v.exp_stall = st; v.exp_bpc = bp; v.exp_jpc = jp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0]  m_ps;
        logic [31:0] m_bp;
        logic [31:0] m_jp;
        logic        m_st;

        //        pc4           inst          m2  exrn  rs_data       rt_data  pcsrc stall bpc           jpc
        add_vec(32'h10,       32'h1022FFFC, 0, 0,  32'd5,        32'd5, 2'd1, 0, 32'h0,        32'h008BFFF0);
        add_vec(32'h10,       32'h1022FFFC, 0, 0,  32'd5,        32'd6, 2'd0, 0, 32'h0,        32'h008BFFF0);
        add_vec(32'h100,      32'h14220003, 0, 0,  32'd7,        32'd7, 2'd0, 0, 32'h10C,      32'h0088000C);
        add_vec(32'h100,      32'h14220003, 0, 0,  32'd7,        32'd8, 2'd1, 0, 32'h10C,      32'h0088000C);
        add_vec(32'h40000008, 32'h08000010, 0, 0,  32'd0,        32'd0, 2'd2, 0, 32'h40000048, 32'h40000040);
        add_vec(32'h40000008, 32'h0C000010, 0, 0,  32'd0,        32'd0, 2'd2, 0, 32'h40000048, 32'h40000040);
        add_vec(32'h40000008, 32'h03E00008, 0, 0,  32'h100,      32'd0, 2'd2, 0, 32'h40000028, 32'h100);
        add_vec(32'h20,       32'h00221820, 1, 2,  32'd0,        32'd0, 2'd0, 1, 32'h60A0,     32'h00886080);
        add_vec(32'h20,       32'h00221820, 1, 3,  32'd0,        32'd0, 2'd0, 0, 32'h60A0,     32'h00886080);
        add_vec(32'h20,       32'h00000000, 1, 0,  32'd0,        32'd0, 2'd0, 0, 32'h20,       32'h0);
        add_vec(32'h40000008, 32'h0BE00010, 1, 31, 32'd0,        32'd0, 2'd2, 0, 32'h40000048, 32'h4F800040);
        add_vec(32'h10,       32'h1022FFFC, 1, 1,  32'd5,        32'd5, 2'd0, 1, 32'h0,        32'h008BFFF0);
        add_vec(32'h20,       32'hAC220004, 1, 2,  32'd0,        32'd0, 2'd0, 1, 32'h30,       32'h00880010);
        add_vec(32'h20,       32'h8C220004, 1, 2,  32'd0,        32'd0, 2'd0, 0, 32'h30,       32'h00880010);
        add_vec(32'h20,       32'h8C220004, 1, 1,  32'd0,        32'd0, 2'd0, 1, 32'h30,       32'h00880010);

        // Reset with a load waiting at fetch.
        clrn = 1'b0; if_pc4 = 32'h44; if_inst = 32'h8C220004;
        ex_m2reg = 1'b0; ex_rn = 5'd0; rs_data = 32'd0; rt_data = 32'd0;
        #12;
        check("reset_id_inst", id_inst, 32'h0);
        check("reset_id_pc4", id_pc4, 32'h0);
        check("reset_pcsource", 32'(pcsource), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_rs_rt", {22'h0, rs, rt}, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            load(vecs[i].pc4, vecs[i].inst);
            ex_m2reg = vecs[i].m2reg; ex_rn = vecs[i].exrn;
            rs_data = vecs[i].rsd; rt_data = vecs[i].rtd;
            #1;
            check($sformatf("vec%0d_pcsource", i), 32'(pcsource), 32'(vecs[i].exp_pcsrc));
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_bpc", i), bpc, vecs[i].exp_bpc);
            check($sformatf("vec%0d_jpc", i), jpc, vecs[i].exp_jpc);
        end

        // Taken beq, then the squashed delay slot arrives as a nop.
        load(32'h10, 32'h1022FFFC);
        rs_data = 32'd5; rt_data = 32'd5;
        @(negedge clk); if_pc4 = 32'h14; if_inst = 32'h0;
        check("beq_taken_pcsource", 32'(pcsource), 32'h1);
        @(posedge clk); #1;
        check("beq_slot_nop", id_inst, 32'h0);
        check("beq_slot_pcsource", 32'(pcsource), 32'h0);

        // Load-use stall holds IF/ID for exactly the stalled cycle.
        load(32'h20, 32'h00221820);
        ex_m2reg = 1'b1; ex_rn = 5'd2;
        @(negedge clk); if_pc4 = 32'h24; if_inst = 32'h12345678;
        check("lu_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        check("lu_held_inst", id_inst, 32'h00221820);
        check("lu_held_pc4", id_pc4, 32'h20);
        ex_m2reg = 1'b0; #1;
        check("lu_release", 32'(stall), 32'h0);
        @(posedge clk); #1;
        check("lu_next_capture", id_inst, 32'h12345678);

        // Stall beats redirect, then the branch resolves.
        load(32'h10, 32'h1022FFFC);
        ex_m2reg = 1'b1; ex_rn = 5'd1; rs_data = 32'd9; rt_data = 32'd9; #1;
        check("sbr_pcsource", 32'(pcsource), 32'h0);
        check("sbr_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        ex_m2reg = 1'b0; #1;
        check("sbr_resolved", 32'(pcsource), 32'h1);
        check("sbr_inst_kept", id_inst, 32'h1022FFFC);

        // Asynchronous reset mid-stall discards the pending instruction.
        load(32'h30, 32'h00221820);
        ex_m2reg = 1'b1; ex_rn = 5'd1; #1;
        clrn = 1'b0; #1;
        check("rst_mid_inst", id_inst, 32'h0);
        check("rst_mid_pc4", id_pc4, 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        @(negedge clk);
        clrn = 1'b1; ex_m2reg = 1'b0; if_pc4 = 32'h80; if_inst = 32'h0C000123;
        @(posedge clk); #1;
        check("rst_first_capture", id_inst, 32'h0C000123);

        // Randomized instruction mix against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  ops[8];
            logic [31:0] inst;
            logic [31:0] pc4;
            ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};
            inst = $urandom;
            inst[31:26] = ops[$urandom_range(0, 7)];
            if (inst[31:26] == 6'd0 && $urandom_range(0, 1) == 1) inst[5:0] = 6'd8;
            pc4 = $urandom & 32'hFFFF_FFFC;
            load(pc4, inst);
            check("rnd_id_inst", id_inst, inst);
            check("rnd_id_pc4", id_pc4, pc4);
            ex_m2reg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       ex_rn = inst[25:21];
                1:       ex_rn = inst[20:16];
                default: ex_rn = 5'($urandom);
            endcase
            rs_data = $urandom;
            rt_data = ($urandom_range(0, 1) == 1) ? rs_data : $urandom;
            #1;
            model(pc4, inst, ex_m2reg, ex_rn, rs_data, rt_data, m_ps, m_bp, m_jp, m_st);
            check("rnd_pcsource", 32'(pcsource), 32'(m_ps));
            check("rnd_stall", 32'(stall), 32'(m_st));
            check("rnd_bpc", bpc, m_bp);
            check("rnd_jpc", jpc, m_jp);
            check("rnd_rs_rt", {22'h0, rs, rt}, {22'h0, inst[25:21], inst[20:16]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_branch_unit.md
ID_BRANCH_UNIT -- requirements
Module: id_branch_unit

Decode-side partner of the fetch stage. Holds the IF/ID pipeline register, resolves branches and jumps in decode, and returns pcsource, bpc, jpc and stall to fetch.

Interface
REQ-001 SHALL have one clock domain, clock port clk; reset port clrn is asynchronous, active-low.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock
- clrn  in  1  async active-low reset
- if_pc4  in  32  fetch PC+4
- if_inst  in  32  fetched instruction; fetch zeroes it on redirect
- ex_m2reg  in  1  instruction in EX is a load
- ex_rn  in  5  destination register of the EX instruction
- rs_data  in  32  operand value for rs, already forwarded
- rt_data  in  32  operand value for rt, already forwarded
- id_pc4  out  32  registered PC+4
- id_inst  out  32  registered instruction
- rs  out  5  = id_inst[25:21]
- rt  out  5  = id_inst[20:16]
- pcsource  out  2  00 = pc4, 01 = bpc, 10 = jpc, 11 unused (never driven)
- bpc  out  32  branch target
- jpc  out  32  jump target
- stall  out  1  hold PC and IF/ID register

Function
REQ-003 On a rising clk with stall=0, SHALL load id_pc4<=if_pc4 and id_inst<=if_inst.
REQ-004 On a rising clk with stall=1, SHALL hold id_pc4 and id_inst unchanged.
REQ-005 Decode SHALL use op = id_inst[31:26] and func = id_inst[5:0], MIPS encoding:
- beq = 000100, bne = 000101
- j = 000010, jal = 000011
- jr = op 000000 with func 001000
REQ-006 bpc SHALL be id_pc4 + ({{14{id_inst[15]}}, id_inst[15:0], 2'b00}), mod 2^32, always driven.
REQ-007 jpc SHALL be:
- rs_data when the instruction is jr
- otherwise {id_pc4[31:28], id_inst[25:0], 2'b00}
REQ-008 uses_rs SHALL be 1 for every op except j and jal.
REQ-009 uses_rt SHALL be 1 for op 000000, beq, bne and sw (101011).
REQ-010 stall SHALL be 1 iff all of the following hold:
- ex_m2reg = 1
- ex_rn != 0
- (ex_rn == rs && uses_rs) || (ex_rn == rt && uses_rt)
REQ-011 When stall=0, pcsource SHALL be:
- 01 for beq with rs_data == rt_data
- 01 for bne with rs_data != rt_data
- 10 for j, jal, jr
- 00 otherwise
REQ-012 When stall=1, pcsource SHALL be 00; redirect waits for the operand.
REQ-013 stall, pcsource, bpc, jpc, rs and rt SHALL be combinational from the registered state and inputs, with zero added latency.
REQ-014 Branch penalty SHALL be one cycle. The delay-slot fetch is squashed by fetch (inst forced to 0), so the next id_inst is a nop (0x00000000).
REQ-015 All-zero id_inst (sll $0) SHALL give pcsource=00. It SHALL never stall, because ex_rn=0 is excluded by REQ-010.
REQ-016 A branch whose operand matches a load in EX SHALL stall exactly one cycle, then resolve on the next cycle.

Reset
REQ-017 clrn=0 SHALL immediately clear id_pc4 and id_inst to 0, independent of clk.
REQ-018 While clrn=0 the outputs SHALL be pcsource=00 and stall=0; with id_inst=0, rs=0 and rt=0.
REQ-019 Reset asserted mid-stall or mid-redirect SHALL discard the pending instruction; after release the first capture SHALL be if_inst.

Verification
REQ-020 Reset: clrn=0 with if_inst=0x8C220004 -> id_inst=0, id_pc4=0, pcsource=00, stall=0.
REQ-021 Taken beq:
- Stimulus: id_pc4=0x00000010, id_inst=0x1022FFFC (beq $1,$2,-4), rs_data=rt_data=5
- Response: pcsource=01, bpc=0x00000000
- Next edge with if_inst=0: id_inst=0
REQ-022 Not-taken bne:
- Stimulus: id_inst=0x14220003, rs_data=rt_data=7
- Response: pcsource=00, bpc=id_pc4+12
REQ-023 j and jr:
- id_pc4=0x40000008, id_inst=0x08000010 -> pcsource=10, jpc=0x40000040
- id_inst=0x03E00008 with rs_data=0x00000100 -> jpc=0x00000100
REQ-024 Load-use stall:
- Stimulus: ex_m2reg=1, ex_rn=2, id_inst=0x00221820 (add $3,$1,$2)
- Response: stall=1, pcsource=00, id_inst held across the edge
- Next cycle with ex_m2reg=0: stall=0
REQ-025 Stall beats redirect:
- Stimulus: beq $1,$2 with ex_m2reg=1, ex_rn=1, rs_data==rt_data
- Response: pcsource=00, stall=1
- Next cycle with ex_m2reg=0: pcsource=01
